wavegen_dds: RTL and testbench

Parametrised direct-digital-synthesis waveform generator that succeeds the fixed 8-bit counter-driven generator. A phase accumulator with a programmable frequency control word replaces the free-running 8-bit counter. The generator produces six waveform modes with run-time amplitude scaling and PWM duty control. Function changes are glitch-free: they take effect only at a phase wrap. The output feeds the lab DAC/display path exactly as the earlier generator's `wave_out` did.

---
 rtl/wavegen_dds.sv | 117 +++++++++++
 tb/tb_wavegen_dds.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wavegen_dds.sv
// Direct-digital-synthesis waveform generator with six modes, amplitude scaling and PWM duty.
// A requested function change waits for the next phase wrap, so no output period is ever torn.
module wavegen_dds #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [2:0]         func,
    input  logic               func_load,
    input  logic [DATA_W-1:0]  duty,
    input  logic [DATA_W-1:0]  amp,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               wrap,
    output logic               switch_pending
);
    localparam logic [2:0] FUNC_SAW   = 3'b000;
    localparam logic [2:0] FUNC_RSAW  = 3'b001;
    localparam logic [2:0] FUNC_TRI   = 3'b010;
    localparam logic [2:0] FUNC_PWM   = 3'b011;
    localparam logic [2:0] FUNC_PARAB = 3'b100;
    localparam logic [2:0] FUNC_NOISE = 3'b101;

    localparam logic [DATA_W-1:0] MAX       = '1;
    localparam logic [15:0]       LFSR_SEED = 16'hACE1;
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;

    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W:0]    sum;
    logic                carry;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [2:0]          active_func;
    logic [2:0]          pending_func;
    logic                take_switch;
    logic [DATA_W-1:0]   p;
    logic [DATA_W-1:0]   q;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_shr;
    logic [DATA_W-1:0]   parab;
    logic [DATA_W-1:0]   raw_next;
    logic [DATA_W-1:0]   raw1;
    logic                valid1;
    logic [DATA_W:0]     amp_p1;
    logic [2*DATA_W:0]   scaled;
    logic [DATA_W-1:0]   scaled_top;

    assign sum   = {1'b0, phase} + {1'b0, fcw};
    assign carry = sum[PHASE_W];

    // Galois form shifting right; taps x^16+x^14+x^13+x^11+1
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    // A load coinciding with the wrap bypasses pending_func and applies at once
    assign take_switch = en & carry & (func_load | switch_pending);

    assign p        = phase[PHASE_W-1 -: DATA_W];
    assign q        = {p[DATA_W-2:0], 1'b0};
    assign prod     = (2*DATA_W)'(q) * (2*DATA_W)'(MAX - q);
    assign prod_shr = prod >> (DATA_W - 2);
    assign parab    = (|prod_shr[2*DATA_W-1:DATA_W]) ? MAX : prod_shr[DATA_W-1:0];

    always_comb begin
        raw_next = '0;
        case (active_func)
            FUNC_SAW:   raw_next = p;
            FUNC_RSAW:  raw_next = MAX - p;
            FUNC_TRI:   raw_next = p[DATA_W-1] ? (MAX - q) : q;
            FUNC_PWM:   raw_next = (p < duty) ? MAX : '0;
            FUNC_PARAB: raw_next = parab;
            FUNC_NOISE: raw_next = lfsr[DATA_W-1:0];
            default:    raw_next = '0;
        endcase
    end

    // amp+1 keeps full-scale amp an exact pass-through
    assign amp_p1     = {1'b0, amp} + (DATA_W+1)'(1);
    assign scaled     = (2*DATA_W+1)'(raw1) * (2*DATA_W+1)'(amp_p1);
    assign scaled_top = DATA_W'(scaled >> DATA_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase          <= '0;
            lfsr           <= LFSR_SEED;
            active_func    <= FUNC_SAW;
            pending_func   <= FUNC_SAW;
            switch_pending <= 1'b0;
            wrap           <= 1'b0;
            raw1           <= '0;
            valid1         <= 1'b0;
            wave_out       <= '0;
            wave_valid     <= 1'b0;
        end else begin
            wrap   <= en & carry;
            valid1 <= en;
            if (en) begin
                phase <= sum[PHASE_W-1:0];
                lfsr  <= lfsr_next;
                raw1  <= raw_next;
            end
            if (take_switch)
                active_func <= func_load ? func : pending_func;
            if (func_load)
                pending_func <= func;
            if (en & carry)
                switch_pending <= 1'b0;
            else if (func_load)
                switch_pending <= 1'b1;
            wave_valid <= valid1;
            if (valid1)
                wave_out <= scaled_top;
        end
    end
endmodule

// File: tb/tb_wavegen_dds.sv
// Bench for wavegen_dds: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against an arithmetic model of the generator.
module tb_wavegen_dds;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] fcw;
    logic [2:0]  func;
    logic        func_load;
    logic [7:0]  duty;
    logic [7:0]  amp;
    logic [7:0]  wave_out;
    logic        wave_valid;
    logic        wrap;
    logic        switch_pending;

    int errors = 0;
    int checks = 0;

    // model state: stage-0 quantities, one sample in flight, the visible output
    int m_phase = 0, m_lfsr = 'hACE1, m_act = 0, m_pend = 0;
    int m_sp = 0, m_wrap = 0;
    int s1_raw = 0, s1_valid = 0;
    int m_out = 0, m_valid = 0;

    wavegen_dds #(.DATA_W(8), .PHASE_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .fcw(fcw), .func(func), .func_load(func_load),
        .duty(duty), .amp(amp), .wave_out(wave_out), .wave_valid(wave_valid),
        .wrap(wrap), .switch_pending(switch_pending)
    );

    always #5 clk = ~clk;

    function automatic int model_raw(int ph, int f, int lf, int du);
        int pp, qq, v;
        pp = ph / 256;
        qq = (2 * pp) % 256;
        case (f)
            0: return pp;
            1: return 255 - pp;
            2: return (pp >= 128) ? 255 - qq : qq;
            3: return (pp < du) ? 255 : 0;
            4: begin
                v = qq * (255 - qq) / 64;
                return (v > 255) ? 255 : v;
            end
            5: return lf % 256;
            default: return 0;
        endcase
    endfunction

    function automatic int lfsr_adv(int lf);
        return (lf % 2 == 1) ? ((lf / 2) ^ 'hB400) : (lf / 2);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int s, c;
        if (rst) begin
            m_phase = 0; m_lfsr = 'hACE1; m_act = 0; m_pend = 0; m_sp = 0; m_wrap = 0;
            s1_raw = 0; s1_valid = 0; m_out = 0; m_valid = 0;
        end else begin
            if (s1_valid != 0)
                m_out = s1_raw * (int'(amp) + 1) / 256;
            m_valid = s1_valid;
            if (en)
                s1_raw = model_raw(m_phase, m_act, m_lfsr, int'(duty));
            s1_valid = int'(en);
            c = 0;
            if (en) begin
                s = m_phase + int'(fcw);
                c = (s > 65535) ? 1 : 0;
                m_phase = s % 65536;
                m_lfsr = lfsr_adv(m_lfsr);
            end
            m_wrap = c;
            if (c != 0 && (func_load || m_sp != 0))
                m_act = func_load ? int'(func) : m_pend;
            if (func_load)
                m_pend = int'(func);
            m_sp = (c != 0) ? 0 : ((m_sp != 0 || func_load) ? 1 : 0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("wave_out", int'(wave_out), m_out);
        check("wave_valid", int'(wave_valid), m_valid);
        check("wrap", int'(wrap), m_wrap);
        check("switch_pending", int'(switch_pending), m_sp);
    endtask

    initial begin
        int pp, hi;
        rst = 1'b1; en = 1'b0; fcw = 16'h0100; func = 3'd0; func_load = 1'b0;
        duty = 8'h40; amp = 8'hFF;
        tick();
        tick();
        check("reset_wave_out", int'(wave_out), 0);
        check("reset_wave_valid", int'(wave_valid), 0);
        check("reset_switch_pending", int'(switch_pending), 0);

        for (int n = 1; n <= 1505; n++) begin
            rst       = (n >= 1500 && n <= 1501);
            en        = !(n >= 1400 && n <= 1409);
            fcw       = (n >= 1502) ? 16'h8000 : 16'h0100;
            amp       = (n >= 1026 && n < 1282) ? 8'h7F : 8'hFF;
            func_load = (n == 305 || n == 768 || n == 1100 || n == 1503);
            func      = (n == 305) ? 3'd2 : (n == 768) ? 3'd3 : (n == 1100) ? 3'd4 : 3'd5;
            tick();

            if (n >= 2 && n <= 1399) begin
                pp = (n - 2) % 256;
                if (n <= 513)
                    check("saw_ramp", int'(wave_out), pp);
                else if (n <= 769) begin
                    if (pp == 0)    check("tri_start", int'(wave_out), 8'h00);
                    if (pp == 8'h7F) check("tri_7f", int'(wave_out), 8'hFE);
                    if (pp == 8'h80) check("tri_80", int'(wave_out), 8'hFF);
                end else if (n <= 1281) begin
                    hi = (n >= 1026) ? 8'h7F : 8'hFF;
                    check("pwm_level", int'(wave_out), (pp < 8'h40) ? hi : 0);
                end else if (pp == 8'h40)
                    check("parab_40", int'(wave_out), 8'hFE);
            end
            if (n <= 1399) begin
                check("wrap_period", int'(wrap), (n % 256 == 0) ? 1 : 0);
                check("pending_window", int'(switch_pending),
                      ((n >= 305 && n <= 511) || (n >= 1100 && n <= 1279)) ? 1 : 0);
            end
            if (n == 1)    check("first_not_valid", int'(wave_valid), 0);
            if (n == 2)    check("first_valid", int'(wave_valid), 1);
            if (n == 1400) check("hold_valid_lag", int'(wave_valid), 1);
            if (n >= 1401 && n <= 1410) check("hold_valid_low", int'(wave_valid), 0);
            if (n >= 1401 && n <= 1409) check("hold_no_wrap", int'(wrap), 0);
            if (n == 1411) check("resume_valid", int'(wave_valid), 1);
            if (n == 1501) begin
                check("midrst_wave_out", int'(wave_out), 0);
                check("midrst_valid", int'(wave_valid), 0);
            end
            if (n == 1503) begin
                check("coincident_wrap", int'(wrap), 1);
                check("coincident_pending", int'(switch_pending), 0);
            end
            if (n == 1505) check("noise_first", int'(wave_out), 8'h38);
        end

        func_load = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0)
                fcw = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(1, 1024));
            func_load = ($urandom_range(0, 19) == 0);
            func      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) duty = 8'($urandom);
            if ($urandom_range(0, 99) == 0) amp = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
